pipeline_ctrl: RTL and testbench

Hazard and sequencing controller for the five-stage pipelined core. It generates stall and flush enables for the F/D, D/E, E/M and M/W pipeline registers, and the ALU operand forwarding selects. It also runs the data-memory request/ready handshake for M-stage loads and stores, freezing the pipeline while memory is busy. It sits beside the datapath and takes register indices and control bits from the D, E, M and W stages.

---
 rtl/pipeline_pkg.sv | 34 +++
 rtl/forward_sel.sv | 44 ++++
 rtl/pipeline_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_pkg
// Description : Shared encodings for the five-stage core hazard controller:
//               result-select codes, forwarding-select codes and the
//               data-memory handshake state type.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

   // Result source selects carried down the pipeline
   localparam logic [1:0] RES_ALU = 2'b00;
   localparam logic [1:0] RES_MEM = 2'b01;
   localparam logic [1:0] RES_PC4 = 2'b10;

   // ALU operand forwarding selects
   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_W   = 2'b01;
   localparam logic [1:0] FWD_M   = 2'b10;

   // Data-memory handshake state
   typedef enum logic [0:0] {
      IDLE = 1'b0,
      WAIT = 1'b1
   } ctrl_state_t;

   // An M-stage instruction touches data memory when it stores or loads
   function automatic logic is_mem_access(input logic       memwrite,
                                          input logic [1:0] result_src);
      return memwrite | (result_src == RES_MEM);
   endfunction

endpackage
`default_nettype wire

// File: rtl/forward_sel.sv
`default_nettype none
// ============================================================================
// Module      : forward_sel
// Description : Selects the source of one E-stage ALU operand. The M-stage
//               ALU result wins over the W-stage result; register x0 is
//               never forwarded.
// Ports       : i_rs_e       E-stage source register index
//               i_rd_m       M-stage destination index
//               i_regwrite_m M-stage register write enable
//               i_rd_w       W-stage destination index
//               i_regwrite_w W-stage register write enable
//               o_fwd        operand select (FWD_RF / FWD_W / FWD_M)
// Revision    : 1.0 - initial release
// ============================================================================
module forward_sel
   import pipeline_pkg::*;
#(
   parameter int WIDTH = 5
) (
   input  logic [WIDTH-1:0] i_rs_e,
   input  logic [WIDTH-1:0] i_rd_m,
   input  logic             i_regwrite_m,
   input  logic [WIDTH-1:0] i_rd_w,
   input  logic             i_regwrite_w,
   output logic [1:0]       o_fwd
);

   logic w_hit_m;
   logic w_hit_w;

   assign w_hit_m = i_regwrite_m && (i_rd_m != '0) && (i_rd_m == i_rs_e);
   assign w_hit_w = i_regwrite_w && (i_rd_w != '0) && (i_rd_w == i_rs_e);

   always_comb begin
      o_fwd = FWD_RF;
      if (w_hit_m) begin
         o_fwd = FWD_M;
      end else if (w_hit_w) begin
         o_fwd = FWD_W;
      end
   end

endmodule
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl
// Description : Hazard and sequencing controller for the five-stage core.
//               Generates pipeline-register stall/flush enables, ALU operand
//               forwarding selects, and runs the data-memory request/ready
//               handshake, freezing the pipeline while memory is busy.
// Ports       : clk, rst              core clock, async active-high reset
//               Rs1D, Rs2D            D-stage sources
//               Rs1E, Rs2E, RdE       E-stage sources / destination
//               ResultSrcE, PCSrcE    E-stage load indicator / branch taken
//               RdM, RegWriteM,
//               MemWriteM, ResultSrcM M-stage destination and controls
//               RdW, RegWriteW        W-stage destination and write enable
//               mem_ready / mem_req   data-memory handshake
//               Stall*/Flush*         pipeline-register controls
//               ForwardAE/BE          operand forwarding selects
//               stall_count           saturating count of StallF cycles
//               mem_err               sticky memory-timeout flag
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ctrl
   import pipeline_pkg::*;
#(
   parameter int WIDTH       = 5,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] Rs1D,
   input  logic [WIDTH-1:0] Rs2D,
   input  logic [WIDTH-1:0] Rs1E,
   input  logic [WIDTH-1:0] Rs2E,
   input  logic [WIDTH-1:0] RdE,
   input  logic [1:0]       ResultSrcE,
   input  logic             PCSrcE,
   input  logic [WIDTH-1:0] RdM,
   input  logic             RegWriteM,
   input  logic             MemWriteM,
   input  logic [1:0]       ResultSrcM,
   input  logic [WIDTH-1:0] RdW,
   input  logic             RegWriteW,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             StallM,
   output logic             FlushD,
   output logic             FlushE,
   output logic             FlushW,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic [31:0]      stall_count,
   output logic             mem_err
);

   localparam int                 c_CNT_W      = $clog2(MEM_TIMEOUT + 1);
   localparam logic [c_CNT_W-1:0] c_TIMEOUT    = c_CNT_W'(MEM_TIMEOUT);
   localparam logic [c_CNT_W-1:0] c_TIMEOUT_M1 = c_CNT_W'(MEM_TIMEOUT - 1);

   ctrl_state_t        r_state;
   logic [c_CNT_W-1:0] r_wait_cnt;
   logic [31:0]        r_stall_count;
   logic               r_mem_err;

   logic w_mem_access;
   logic w_mem_stall;
   logic w_lw_stall;

   assign w_mem_access = is_mem_access(MemWriteM, ResultSrcM);

   // Stall as soon as an access is outstanding without ready, including its
   // very first cycle, so a single-cycle memory costs nothing.
   assign w_mem_stall = ((r_state == IDLE) && w_mem_access && !mem_ready) ||
                        ((r_state == WAIT) && !mem_ready);

   assign w_lw_stall = (ResultSrcE == RES_MEM) && (RdE != '0) &&
                       ((RdE == Rs1D) || (RdE == Rs2D));

   // ------------------------------------------------------------------------
   // Stall / flush / request generation
   // ------------------------------------------------------------------------
   always_comb begin
      StallF = 1'b0;
      StallD = 1'b0;
      StallE = 1'b0;
      StallM = 1'b0;
      FlushD = 1'b0;
      FlushE = 1'b0;
      FlushW = 1'b0;
      if (w_mem_stall) begin
         // Whole pipe frozen; branch and load-use are not acted on here
         // because the same instructions are still present after release.
         StallF = 1'b1;
         StallD = 1'b1;
         StallE = 1'b1;
         StallM = 1'b1;
         FlushW = 1'b1;
      end else begin
         StallF = w_lw_stall;
         StallD = w_lw_stall;
         FlushD = PCSrcE;
         FlushE = w_lw_stall | PCSrcE;
      end
   end

   // Request held from issue through the ready cycle; killed while in reset
   always_comb begin
      mem_req = 1'b0;
      if (!rst) begin
         mem_req = (r_state == WAIT) || w_mem_access;
      end
   end

   // ------------------------------------------------------------------------
   // Operand forwarding
   // ------------------------------------------------------------------------
   forward_sel #(
      .WIDTH        (WIDTH)
   ) u_fwd_a (
      .i_rs_e       (Rs1E),
      .i_rd_m       (RdM),
      .i_regwrite_m (RegWriteM),
      .i_rd_w       (RdW),
      .i_regwrite_w (RegWriteW),
      .o_fwd        (ForwardAE)
   );

   forward_sel #(
      .WIDTH        (WIDTH)
   ) u_fwd_b (
      .i_rs_e       (Rs2E),
      .i_rd_m       (RdM),
      .i_regwrite_m (RegWriteM),
      .i_rd_w       (RdW),
      .i_regwrite_w (RegWriteW),
      .o_fwd        (ForwardBE)
   );

   // ------------------------------------------------------------------------
   // Handshake FSM, timeout watchdog and stall statistics
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= IDLE;
         r_wait_cnt    <= '0;
         r_mem_err     <= 1'b0;
         r_stall_count <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_mem_access && !mem_ready) begin
                  r_state    <= WAIT;
                  r_wait_cnt <= '0;
               end
            end
            WAIT: begin
               // Counter saturates at the limit; the flag latches the cycle
               // the count reaches it and only reset clears it.
               if (r_wait_cnt != c_TIMEOUT) begin
                  r_wait_cnt <= r_wait_cnt + 1'b1;
               end
               if (r_wait_cnt == c_TIMEOUT_M1) begin
                  r_mem_err <= 1'b1;
               end
               if (mem_ready) begin
                  r_state <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase

         if (StallF && (r_stall_count != 32'hFFFF_FFFF)) begin
            r_stall_count <= r_stall_count + 32'd1;
         end
      end
   end

   assign stall_count = r_stall_count;
   assign mem_err     = r_mem_err;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_ctrl
// Description : Self-checking bench for pipeline_ctrl. Each scenario pushes
//               the expected control vector when it drives a cycle and pops
//               it for comparison at the following falling edge.
//               Vector layout: {StallF,StallD,StallE,StallM,FlushD,FlushE,
//               FlushW,mem_req,ForwardAE,ForwardBE}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;

   localparam int WIDTH = 5;

   logic             clk;
   logic             rst;
   logic [WIDTH-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
   logic [1:0]       ResultSrcE, ResultSrcM;
   logic             PCSrcE, RegWriteM, MemWriteM, RegWriteW, mem_ready;
   logic             mem_req, StallF, StallD, StallE, StallM;
   logic             FlushD, FlushE, FlushW;
   logic [1:0]       ForwardAE, ForwardBE;
   logic [31:0]      stall_count;
   logic             mem_err;

   logic [11:0]      w_obs;
   assign w_obs = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
                   mem_req, ForwardAE, ForwardBE};

   typedef struct {
      string       name;
      logic [11:0] exp;
   } exp_t;

   exp_t        sb[$];
   exp_t        e;
   int          n_cmp;
   int          n_err;
   logic [31:0] exp_sc;

   pipeline_ctrl #(
      .WIDTH       (WIDTH),
      .MEM_TIMEOUT (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .Rs1D        (Rs1D),
      .Rs2D        (Rs2D),
      .Rs1E        (Rs1E),
      .Rs2E        (Rs2E),
      .RdE         (RdE),
      .ResultSrcE  (ResultSrcE),
      .PCSrcE      (PCSrcE),
      .RdM         (RdM),
      .RegWriteM   (RegWriteM),
      .MemWriteM   (MemWriteM),
      .ResultSrcM  (ResultSrcM),
      .RdW         (RdW),
      .RegWriteW   (RegWriteW),
      .mem_ready   (mem_ready),
      .mem_req     (mem_req),
      .StallF      (StallF),
      .StallD      (StallD),
      .StallE      (StallE),
      .StallM      (StallM),
      .FlushD      (FlushD),
      .FlushE      (FlushE),
      .FlushW      (FlushW),
      .ForwardAE   (ForwardAE),
      .ForwardBE   (ForwardBE),
      .stall_count (stall_count),
      .mem_err     (mem_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic clear_inputs();
      Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0;
      RdM = '0; RdW = '0; ResultSrcE = 2'b00; ResultSrcM = 2'b00;
      PCSrcE = 1'b0; RegWriteM = 1'b0; MemWriteM = 1'b0;
      RegWriteW = 1'b0; mem_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      clear_inputs();
      sb.push_back('{"reset_outputs", 12'h000});
      @(negedge clk);
      e = sb.pop_front();
      n_cmp++;
      if (w_obs !== e.exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b", e.name, w_obs, e.exp);
      end
      n_cmp++;
      if (stall_count !== 32'd0) begin
         n_err++;
         $display("FAIL reset_stall_count: got %0d expected 0", stall_count);
      end
      n_cmp++;
      if (mem_err !== 1'b0) begin
         n_err++;
         $display("FAIL reset_mem_err: got %b expected 0", mem_err);
      end
      MemWriteM = 1'b1;
      #1;
      n_cmp++;
      if (mem_req !== 1'b0) begin
         n_err++;
         $display("FAIL reset_mem_req_forced: got %b expected 0", mem_req);
      end
      MemWriteM = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      exp_sc = '0;
   endtask

   task automatic test_forwarding();
      // {RegWriteM, RdM, RegWriteW, RdW, Rs1E, Rs2E}
      logic [21:0] stim [6];
      logic [11:0] expv [6];
      stim[0] = {1'b1, 5'd5, 1'b1, 5'd5, 5'd5, 5'd3}; expv[0] = 12'h008;
      stim[1] = {1'b1, 5'd0, 1'b1, 5'd5, 5'd5, 5'd3}; expv[1] = 12'h004;
      stim[2] = {1'b0, 5'd5, 1'b1, 5'd5, 5'd5, 5'd5}; expv[2] = 12'h005;
      stim[3] = {1'b1, 5'd5, 1'b1, 5'd9, 5'd9, 5'd5}; expv[3] = 12'h006;
      stim[4] = {1'b1, 5'd5, 1'b0, 5'd9, 5'd9, 5'd5}; expv[4] = 12'h002;
      stim[5] = {1'b1, 5'd0, 1'b1, 5'd0, 5'd0, 5'd0}; expv[5] = 12'h000;
      for (int i = 0; i < 6; i++) begin
         clear_inputs();
         {RegWriteM, RdM, RegWriteW, RdW, Rs1E, Rs2E} = stim[i];
         sb.push_back('{$sformatf("forward_%0d", i), expv[i]});
         @(negedge clk);
         e = sb.pop_front();
         n_cmp++;
         if (w_obs !== e.exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", e.name, w_obs, e.exp);
         end
         if (e.exp[11]) exp_sc++;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_load_use();
      // {ResultSrcE, RdE, Rs1D, Rs2D}
      logic [16:0] stim [5];
      logic [11:0] expv [5];
      stim[0] = {2'b01, 5'd7, 5'd0, 5'd7}; expv[0] = 12'hC40;
      stim[1] = {2'b00, 5'd0, 5'd0, 5'd0}; expv[1] = 12'h000;
      stim[2] = {2'b01, 5'd0, 5'd0, 5'd0}; expv[2] = 12'h000;
      stim[3] = {2'b00, 5'd7, 5'd7, 5'd0}; expv[3] = 12'h000;
      stim[4] = {2'b01, 5'd7, 5'd7, 5'd2}; expv[4] = 12'hC40;
      for (int i = 0; i < 5; i++) begin
         clear_inputs();
         {ResultSrcE, RdE, Rs1D, Rs2D} = stim[i];
         sb.push_back('{$sformatf("load_use_%0d", i), expv[i]});
         @(negedge clk);
         e = sb.pop_front();
         n_cmp++;
         if (w_obs !== e.exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", e.name, w_obs, e.exp);
         end
         if (e.exp[11]) exp_sc++;
         @(posedge clk);
         #1;
         if (i == 0) begin
            n_cmp++;
            if (stall_count !== 32'd1) begin
               n_err++;
               $display("FAIL load_use_stall_count: got %0d expected 1",
                        stall_count);
            end
         end
      end
      n_cmp++;
      if (stall_count !== exp_sc) begin
         n_err++;
         $display("FAIL load_use_stall_total: got %0d expected %0d",
                  stall_count, exp_sc);
      end
   endtask

   task automatic test_branch();
      for (int i = 0; i < 2; i++) begin
         clear_inputs();
         PCSrcE = 1'b1;
         if (i == 1) begin
            ResultSrcE = 2'b01; RdE = 5'd3; Rs1D = 5'd3;
            sb.push_back('{"branch_with_load_use", 12'hCC0});
         end else begin
            sb.push_back('{"branch_flush", 12'h0C0});
         end
         @(negedge clk);
         e = sb.pop_front();
         n_cmp++;
         if (w_obs !== e.exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", e.name, w_obs, e.exp);
         end
         if (e.exp[11]) exp_sc++;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_mem_wait();
      // {MemWriteM, ResultSrcM, mem_ready, PCSrcE}; operand A forwarded
      // from M throughout to show forwarding ignores the freeze.
      logic [4:0]  stim [9];
      logic [11:0] expv [9];
      stim[0] = {1'b1, 2'b00, 1'b0, 1'b0}; expv[0] = 12'hF38;
      stim[1] = {1'b1, 2'b00, 1'b0, 1'b1}; expv[1] = 12'hF38;
      stim[2] = {1'b1, 2'b00, 1'b0, 1'b0}; expv[2] = 12'hF38;
      stim[3] = {1'b1, 2'b00, 1'b1, 1'b0}; expv[3] = 12'h018;
      stim[4] = {1'b0, 2'b00, 1'b0, 1'b0}; expv[4] = 12'h008;
      stim[5] = {1'b0, 2'b01, 1'b1, 1'b0}; expv[5] = 12'h018;
      stim[6] = {1'b0, 2'b01, 1'b0, 1'b0}; expv[6] = 12'hF38;
      stim[7] = {1'b0, 2'b00, 1'b1, 1'b0}; expv[7] = 12'h018;
      stim[8] = {1'b0, 2'b00, 1'b0, 1'b0}; expv[8] = 12'h008;
      for (int i = 0; i < 9; i++) begin
         clear_inputs();
         RegWriteM = 1'b1; RdM = 5'd4; Rs1E = 5'd4;
         {MemWriteM, ResultSrcM, mem_ready, PCSrcE} = stim[i];
         sb.push_back('{$sformatf("mem_wait_%0d", i), expv[i]});
         @(negedge clk);
         e = sb.pop_front();
         n_cmp++;
         if (w_obs !== e.exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", e.name, w_obs, e.exp);
         end
         if (e.exp[11]) exp_sc++;
         @(posedge clk);
         #1;
      end
      n_cmp++;
      if (stall_count !== exp_sc) begin
         n_err++;
         $display("FAIL mem_wait_stall_count: got %0d expected %0d",
                  stall_count, exp_sc);
      end
      n_cmp++;
      if (mem_err !== 1'b0) begin
         n_err++;
         $display("FAIL mem_wait_no_err: got %b expected 0", mem_err);
      end
   endtask

   task automatic test_timeout();
      // Cycle 0 is the IDLE issue cycle; cycles 1..4 are WAIT cycles
      for (int i = 0; i < 5; i++) begin
         clear_inputs();
         MemWriteM = 1'b1;
         sb.push_back('{$sformatf("timeout_stall_%0d", i), 12'hF30});
         @(negedge clk);
         e = sb.pop_front();
         n_cmp++;
         if (w_obs !== e.exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", e.name, w_obs, e.exp);
         end
         if (e.exp[11]) exp_sc++;
         @(posedge clk);
         #1;
         if (i >= 3) begin
            n_cmp++;
            if (mem_err !== (i == 4)) begin
               n_err++;
               $display("FAIL timeout_err_wait%0d: got %b expected %b",
                        i, mem_err, (i == 4));
            end
         end
      end
      clear_inputs();
      MemWriteM = 1'b1;
      mem_ready = 1'b1;
      sb.push_back('{"timeout_release", 12'h010});
      @(negedge clk);
      e = sb.pop_front();
      n_cmp++;
      if (w_obs !== e.exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b", e.name, w_obs, e.exp);
      end
      @(posedge clk);
      #1;
      clear_inputs();
      @(posedge clk);
      #1;
      n_cmp++;
      if (mem_err !== 1'b1) begin
         n_err++;
         $display("FAIL timeout_err_sticky: got %b expected 1", mem_err);
      end
      n_cmp++;
      if (stall_count !== exp_sc) begin
         n_err++;
         $display("FAIL timeout_stall_count: got %0d expected %0d",
                  stall_count, exp_sc);
      end
   endtask

   task automatic test_reset_mid_wait();
      clear_inputs();
      MemWriteM = 1'b1;
      @(posedge clk);
      #1;
      sb.push_back('{"mid_wait_stall", 12'hF30});
      @(negedge clk);
      e = sb.pop_front();
      n_cmp++;
      if (w_obs !== e.exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b", e.name, w_obs, e.exp);
      end
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if (mem_req !== 1'b0) begin
         n_err++;
         $display("FAIL mid_wait_reset_mem_req: got %b expected 0", mem_req);
      end
      clear_inputs();
      @(posedge clk);
      #1 rst = 1'b0;
      exp_sc = '0;
      sb.push_back('{"after_reset_idle", 12'h000});
      @(negedge clk);
      e = sb.pop_front();
      n_cmp++;
      if (w_obs !== e.exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b", e.name, w_obs, e.exp);
      end
      n_cmp++;
      if (stall_count !== 32'd0) begin
         n_err++;
         $display("FAIL after_reset_stall_count: got %0d expected 0",
                  stall_count);
      end
      n_cmp++;
      if (mem_err !== 1'b0) begin
         n_err++;
         $display("FAIL after_reset_mem_err: got %b expected 0", mem_err);
      end
   endtask

   initial begin
      n_cmp  = 0;
      n_err  = 0;
      exp_sc = '0;
      test_reset();
      test_forwarding();
      test_load_use();
      test_branch();
      test_mem_wait();
      test_timeout();
      test_reset_mid_wait();
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain: got %0d entries expected 0",
                  sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
